// File: rtl/bus_arbiter_pkg.sv
// Shared arbiter definitions: state encoding, requester count, index width,
// and the rotating-priority search used to pick the next owner.
package bus_arbiter_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // First set request at or after ptr, wrapping; the descending loop leaves
  // the smallest offset as the final assignment.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/bus_arbiter_decoder.sv
// 3-to-8 decoder with enable; output is all-zero when disabled.
module decoder
  import bus_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0] sel_i,
  input  logic             en_i,
  output logic [NREQ-1:0]  dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) dec_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin 8-way arbiter (IDLE -> GRANT -> RELEASE), one cycle grant latency.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_id,
  output logic             busy,
  output logic             timeout
);

  if (MAX_HOLD < 1) begin : g_hold_chk
    $error("MAX_HOLD must be at least 1");
  end

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_id_q;
  logic             timeout_q;

  logic [IDX_W-1:0] pick_d;
  logic             owner_drop;
  logic             expire;

  assign pick_d     = rr_pick(req, ptr_q);
  assign owner_drop = done || !req[grant_id_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [CW-1:0] hold_cnt_q;
  logic [CW-1:0] hold_cnt_d;

  // Counter is zero on the first GRANT cycle and counts grant cycles held so far.
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == ST_GRANT) hold_cnt_d = hold_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end

  assign expire = (state_q == ST_GRANT) && (hold_cnt_q == CW'(MAX_HOLD - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant_id_q <= pick_d;
            state_q    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A normal release on the expiry cycle takes precedence over the timeout.
          if (owner_drop || expire) begin
            state_q   <= ST_RELEASE;
            ptr_q     <= grant_id_q + IDX_W'(1);
            timeout_q <= expire && !owner_drop;
          end
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  decoder u_decoder (
    .sel_i (grant_id_q),
    .en_i  (state_q == ST_GRANT),
    .dec_o (grant)
  );

  assign grant_id = grant_id_q;
  assign busy     = (state_q != ST_IDLE);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against an owner/queue-level model.
module tb_bus_arbiter;

  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout;

  int n_chk = 0;
  int n_bad = 0;

  // Model: who owns the bus (-1 none), whether we sit in the dead cycle,
  // last owner, rotating start point, cycles held, and pending timeout pulse.
  int m_owner, m_last, m_ptr, m_held;
  bit m_dead, m_tp;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input logic [7:0] q, input bit d);
    if (r) begin
      m_owner = -1; m_dead = 0; m_last = 0; m_ptr = 0; m_held = 0; m_tp = 0;
    end else begin
      m_tp = 0;
      if (m_owner >= 0) begin
        m_held++;
        if (d || !q[m_owner]) begin
          m_ptr = (m_owner + 1) % 8; m_owner = -1; m_dead = 1;
        end else if (TMO_EN && m_held >= MH) begin
          m_ptr = (m_owner + 1) % 8; m_owner = -1; m_dead = 1; m_tp = 1;
        end
      end else if (m_dead) begin
        m_dead = 0;
      end else if (q != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (m_owner < 0 && q[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
        end
        m_last = m_owner;
        m_held = 0;
      end
    end
  endtask

  task automatic step(input bit r, input logic [7:0] q, input bit d);
    logic [7:0] exp_g;
    reset = r; req = q; done = d;
    @(posedge clk);
    model_edge(r, q, d);
    #1;
    exp_g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    check_eq("grant", grant, exp_g);
    check_eq("grant_id", grant_id, m_last);
    check_eq("busy", busy, (m_owner >= 0) || m_dead);
    check_eq("timeout", timeout, m_tp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tmo_cnt;
    logic [7:0] rq;
    reset = 1'b1; req = 8'h00; done = 1'b0;
    m_owner = -1; m_dead = 0; m_last = 0; m_ptr = 0; m_held = 0; m_tp = 0;

    // Reset dominates a full request vector; first grant is requester 0.
    step(1, 8'hFF, 0);
    step(1, 8'hFF, 0);
    check_eq("rst_grant", grant, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_gid", grant_id, 3'd0);
    step(0, 8'hFF, 0);
    check_eq("post_rst_grant", grant, 8'h01);

    // Single requester with a done pulse.
    repeat (3) step(0, 8'h00, 0);
    step(0, 8'h08, 0);
    check_eq("single_grant", grant, 8'h08);
    check_eq("single_gid", grant_id, 3'd3);
    check_eq("single_busy", busy, 1'b1);
    step(0, 8'h08, 1);
    check_eq("single_rel_grant", grant, 8'h00);
    check_eq("single_rel_busy", busy, 1'b1);
    step(0, 8'h08, 0);
    check_eq("single_idle_busy", busy, 1'b0);
    check_eq("single_keep_gid", grant_id, 3'd3);

    // Round-robin rotation with all requests held.
    step(1, 8'hFF, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 8'hFF, 0);
      check_eq("rr_gid", grant_id, i % 8);
      step(0, 8'hFF, 1);
      step(0, 8'hFF, 0);
    end

    // Wrap of the pointer past 7.
    step(1, 8'h00, 0);
    step(0, 8'h40, 0);
    check_eq("wrap_own6", grant, 8'h40);
    step(0, 8'h40, 1);
    step(0, 8'h41, 0);
    step(0, 8'h41, 0);
    check_eq("wrap_grant", grant, 8'h01);

    // Long hold: forced release when enabled, indefinite hold otherwise.
    step(1, 8'h00, 0);
    tmo_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, 8'h60, 0);
      if (timeout) tmo_cnt++;
    end
    check_eq("tmo_seen", tmo_cnt > 0, TMO_EN);

    // Reset in the middle of a grant.
    step(1, 8'h00, 0);
    step(0, 8'h04, 0);
    check_eq("mid_own2", grant, 8'h04);
    step(1, 8'h04, 0);
    check_eq("mid_rst_grant", grant, 8'h00);
    step(0, 8'h06, 0);
    check_eq("mid_next_grant", grant, 8'h02);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rq = 8'($urandom) & 8'($urandom) & 8'($urandom_range(0, 255));
      step($urandom_range(0, 99) < 2, rq, $urandom_range(0, 99) < 25);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
